// File: rtl/maxp_ctrl_if.sv
// Bundles the max-pool controller's handshake, configuration and loop-index signals.
// The master side drives the request and configuration; the slave side is the controller.
interface maxp_ctrl_if #(
    parameter int DATA_SIZE = 16,
    parameter int LOOP_BIT  = 8
);
    logic                 start;
    logic                 hold;
    logic [DATA_SIZE-1:0] M;
    logic [DATA_SIZE-1:0] ROUT;
    logic [DATA_SIZE-1:0] COUT;
    logic [DATA_SIZE-1:0] MP;
    logic [DATA_SIZE-1:0] nP;
    logic                 en;
    logic [LOOP_BIT-1:0]  mm;
    logic [LOOP_BIT-1:0]  niro;
    logic [LOOP_BIT-1:0]  nico;
    logic [LOOP_BIT-1:0]  ii;
    logic [LOOP_BIT-1:0]  jj;
    logic [LOOP_BIT-1:0]  nirr;
    logic [LOOP_BIT-1:0]  nicc;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output start, hold, M, ROUT, COUT, MP, nP,
        input  en, mm, niro, nico, ii, jj, nirr, nicc, busy, done, err
    );

    modport slave (
        input  start, hold, M, ROUT, COUT, MP, nP,
        output en, mm, niro, nico, ii, jj, nirr, nicc, busy, done, err
    );
endinterface

// File: rtl/maxp_ctrl.sv
// Max-pool loop-nest controller: walks (mm, niro, nico, ii, jj) once per accepted start,
// strobing en for every index tuple, then drains the address pipeline and pulses done.
//
// state | meaning
// IDLE  | waiting for start; configuration latched on an accepted start
// RUN   | loop nest active; en = !hold, indices advance on every en cycle
// DRAIN | DRAIN_CYC cycles with en=0 so the address pipeline can empty
// DONE  | one-cycle done pulse, then back to IDLE
module maxp_ctrl #(
    parameter int DATA_SIZE = 16,
    parameter int LOOP_BIT  = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic           clk,
    input  logic           rst,
    maxp_ctrl_if.slave     bus
);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [DATA_SIZE-1:0] m_r, rout_r, cout_r, mp_r, np_r;
    logic [LOOP_BIT-1:0]  mm, niro, nico, ii, jj;
    logic [DW-1:0]        drain_cnt;
    logic                 busy, done, err;

    // Loop bounds use the latched configuration truncated to the index width.
    logic [LOOP_BIT-1:0]  m_max, rout_max, cout_max, mp_max;
    logic                 jj_last, ii_last, nico_last, niro_last, mm_last;
    logic                 cfg_zero;

    assign m_max    = m_r[LOOP_BIT-1:0]    - LOOP_BIT'(1);
    assign rout_max = rout_r[LOOP_BIT-1:0] - LOOP_BIT'(1);
    assign cout_max = cout_r[LOOP_BIT-1:0] - LOOP_BIT'(1);
    assign mp_max   = mp_r[LOOP_BIT-1:0]   - LOOP_BIT'(1);

    assign jj_last   = (jj   == mp_max);
    assign ii_last   = (ii   == mp_max);
    assign nico_last = (nico == cout_max);
    assign niro_last = (niro == rout_max);
    assign mm_last   = (mm   == m_max);

    assign cfg_zero = (bus.M == '0) || (bus.ROUT == '0) || (bus.COUT == '0) || (bus.MP == '0);

    // Sequencer and loop-nest counters; the carry chain runs jj -> ii -> nico -> niro -> mm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            m_r       <= '0;
            rout_r    <= '0;
            cout_r    <= '0;
            mp_r      <= '0;
            np_r      <= '0;
            mm        <= '0;
            niro      <= '0;
            nico      <= '0;
            ii        <= '0;
            jj        <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_r    <= bus.M;
                        rout_r <= bus.ROUT;
                        cout_r <= bus.COUT;
                        mp_r   <= bus.MP;
                        np_r   <= bus.nP;
                        mm     <= '0;
                        niro   <= '0;
                        nico   <= '0;
                        ii     <= '0;
                        jj     <= '0;
                        if (cfg_zero) begin
                            state <= DONE;
                            err   <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= RUN;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (!bus.hold) begin
                        if (jj_last && ii_last && nico_last && niro_last && mm_last) begin
                            mm   <= '0;
                            niro <= '0;
                            nico <= '0;
                            ii   <= '0;
                            jj   <= '0;
                            if (DRAIN_CYC == 0) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state     <= DRAIN;
                                drain_cnt <= DW'(DRAIN_CYC - 1);
                            end
                        end else if (!jj_last) begin
                            jj <= jj + LOOP_BIT'(1);
                        end else begin
                            jj <= '0;
                            if (!ii_last) begin
                                ii <= ii + LOOP_BIT'(1);
                            end else begin
                                ii <= '0;
                                if (!nico_last) begin
                                    nico <= nico + LOOP_BIT'(1);
                                end else begin
                                    nico <= '0;
                                    if (!niro_last) begin
                                        niro <= niro + LOOP_BIT'(1);
                                    end else begin
                                        niro <= '0;
                                        mm   <= mm + LOOP_BIT'(1);
                                    end
                                end
                            end
                        end
                    end
                end

                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Issue strobe and edge markers are combinational so a stall takes effect in the same cycle.
    assign bus.en   = (state == RUN) && !bus.hold;
    assign bus.nirr = niro_last ? np_r[LOOP_BIT-1:0] : '0;
    assign bus.nicc = nico_last ? np_r[LOOP_BIT-1:0] : '0;

    assign bus.mm   = mm;
    assign bus.niro = niro;
    assign bus.nico = nico;
    assign bus.ii   = ii;
    assign bus.jj   = jj;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.err  = err;
endmodule

// File: tb/tb_maxp_ctrl.sv
// Scoreboard bench for maxp_ctrl: expected index tuples (with edge markers) are queued
// when a pass is requested and popped on every en cycle.
module tb_maxp_ctrl;
    localparam int DS    = 16;
    localparam int LB    = 8;
    localparam int DRAIN = 2;

    logic clk;
    logic rst;

    maxp_ctrl_if #(.DATA_SIZE(DS), .LOOP_BIT(LB)) bus ();

    maxp_ctrl #(.DATA_SIZE(DS), .LOOP_BIT(LB), .DRAIN_CYC(DRAIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [55:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] observed();
        return {bus.mm, bus.niro, bus.nico, bus.ii, bus.jj, bus.nirr, bus.nicc};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " en"},   64'(bus.en),   0);
        check({tag, " busy"}, 64'(bus.busy), 0);
        check({tag, " done"}, 64'(bus.done), 0);
        check({tag, " err"},  64'(bus.err),  0);
        check({tag, " idx"},  64'(observed()), 0);
    endtask

    // One pass: request it, compare every en cycle against the queue, then check totals.
    task automatic run_pass(input string name, input int m, input int rout, input int cout,
                            input int mp, input int np, input int h0, input int h1,
                            input bit keep_start);
        int  c, en_cnt, done_at, total, stall, exp_done;
        bit  bad;
        logic [7:0] np8;
        logic [55:0] e;
        bad   = (m == 0) || (rout == 0) || (cout == 0) || (mp == 0);
        total = bad ? 0 : m * rout * cout * mp * mp;
        stall = (h1 >= h0) ? (h1 - h0 + 1) : 0;
        exp_done = bad ? 1 : total + stall + DRAIN + 1;
        np8 = 8'(np);
        exp_q.delete();
        if (!bad) begin
            for (int a = 0; a < m; a++)
                for (int b = 0; b < rout; b++)
                    for (int d = 0; d < cout; d++)
                        for (int i = 0; i < mp; i++)
                            for (int j = 0; j < mp; j++)
                                exp_q.push_back({8'(a), 8'(b), 8'(d), 8'(i), 8'(j),
                                                 (b == rout - 1) ? np8 : 8'd0,
                                                 (d == cout - 1) ? np8 : 8'd0});
        end

        @(negedge clk);
        bus.M = 16'(m); bus.ROUT = 16'(rout); bus.COUT = 16'(cout);
        bus.MP = 16'(mp); bus.nP = 16'(np);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) bus.start = 1'b0;

        c = 0; en_cnt = 0; done_at = -1;
        while (c < 400) begin
            c++;
            bus.hold = (c >= h0) && (c <= h1);
            @(negedge clk);
            if (c == 1) check({name, " err"}, 64'(bus.err), 64'(bad));
            if (bus.en) begin
                en_cnt++;
                if (exp_q.size() == 0) check({name, " extra en"}, 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check({name, " tuple"}, 64'(observed()), 64'(e));
                end
            end
            if (bus.hold) check({name, " en in stall"}, 64'(bus.en), 0);
            if (bus.done) begin
                done_at = c;
                check({name, " busy at done"}, 64'(bus.busy), 0);
                break;
            end
            check({name, " busy"}, 64'(bus.busy), 1);
            @(posedge clk);
            #1;
        end
        bus.hold = 1'b0;
        check({name, " done cycle"}, 64'(done_at), 64'(exp_done));
        check({name, " en count"}, 64'(en_cnt), 64'(total));
        check({name, " queue left"}, 64'(exp_q.size()), 0);

        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check({name, " done pulse"}, 64'(bus.done), 0);
        check({name, " idle busy"}, 64'(bus.busy), 0);
        check({name, " idle en"}, 64'(bus.en), 0);
        check({name, " err kept"}, 64'(bus.err), 64'(bad));
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.hold = 1'b0;
        bus.M = '0; bus.ROUT = '0; bus.COUT = '0; bus.MP = '0; bus.nP = '0;
        #1;
        check_all_zero("reset");
        check("reset nirr", 64'(bus.nirr), 0);
        check("reset nicc", 64'(bus.nicc), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_pass("basic",   1, 2, 2, 2, 1, 0, -1, 1'b0);
        run_pass("stall",   1, 2, 2, 2, 1, 5, 7,  1'b0);
        run_pass("cout3",   1, 1, 3, 1, 2, 0, -1, 1'b0);
        run_pass("rout3",   1, 3, 1, 1, 2, 0, -1, 1'b0);
        run_pass("carry",   2, 2, 3, 3, 5, 4, 4,  1'b0);
        run_pass("mp0",     1, 2, 2, 0, 1, 0, -1, 1'b0);
        repeat (5) @(negedge clk);
        check("mp0 err retained", 64'(bus.err), 1);
        check("mp0 still idle", 64'(bus.busy), 0);
        run_pass("after_err", 1, 2, 2, 2, 1, 0, -1, 1'b0);

        // Reset in cycle 8 of a pass, then a clean pass.
        @(negedge clk);
        bus.M = 16'd1; bus.ROUT = 16'd2; bus.COUT = 16'd2; bus.MP = 16'd2; bus.nP = 16'd1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        check("pre-reset busy", 64'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check_all_zero("midpass reset");
        check("midpass nirr", 64'(bus.nirr), 0);
        check("midpass nicc", 64'(bus.nicc), 0);
        @(negedge clk);
        rst = 1'b0;
        run_pass("post_reset", 1, 2, 2, 2, 1, 0, -1, 1'b0);

        run_pass("start_held", 1, 2, 2, 2, 1, 0, -1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("no restart", 64'(bus.busy), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/maxp_ctrl.md
MAXP_CTRL -- requirements
Module: maxp_ctrl

Interface
REQ-001 Parameter DATA_SIZE, default 16, width of configuration inputs.
REQ-002 Parameter LOOP_BIT, default 8, width of every loop-index output.
REQ-003 Parameter DRAIN_CYC, default 2, post-loop cycles allowed for the address pipeline to empty.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to run one max-pool pass.
REQ-007 hold  input  1  stall; freezes the loop nest while high.
REQ-008 M  input  DATA_SIZE  number of feature maps.
REQ-009 ROUT, COUT  input  DATA_SIZE each  output rows and output columns per map.
REQ-010 MP  input  DATA_SIZE  pooling window edge.
REQ-011 nP  input  DATA_SIZE  padding value reported on edge rows and columns.
REQ-012 en  output  1  address-generator advance strobe.
REQ-013 mm, niro, nico, ii, jj  output  LOOP_BIT each  loop indices, outer to inner.
REQ-014 nirr, nicc  output  LOOP_BIT each  last-row and last-column markers.
REQ-015 busy, done, err  output  1 each  pass active; pass-complete pulse; bad-configuration flag.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-017 In IDLE, start=1 SHALL latch M, ROUT, COUT, MP and nP into internal registers; all later use SHALL read only the latched copies.
REQ-018 At the start edge, if any latched value among M, ROUT, COUT and MP is 0, the FSM SHALL go to DONE with err=1; otherwise it SHALL go to RUN with err=0 and all indices at 0.
REQ-019 The loop nest SHALL be mm 0..M-1 > niro 0..ROUT-1 > nico 0..COUT-1 > ii 0..MP-1 > jj 0..MP-1, with jj innermost.
REQ-020 In RUN, en SHALL be combinationally equal to !hold.
REQ-021 In RUN, when en=1 the indices SHALL advance one step at the clock edge: jj increments; on wrap it resets to 0 and carries into ii; carries propagate outward the same way.
REQ-022 In RUN, when hold=1 all indices and the state SHALL be held unchanged.
REQ-023 The en=1 cycle in which every index equals its maximum SHALL be the final issue; the indices SHALL then clear to 0 and the FSM SHALL go to DRAIN.
REQ-024 Exactly M*ROUT*COUT*MP*MP en cycles SHALL occur per valid pass, with no skipped or repeated index tuple.
REQ-025 nirr SHALL equal nP[LOOP_BIT-1:0] when niro==ROUT-1, otherwise 0; nicc SHALL equal nP[LOOP_BIT-1:0] when nico==COUT-1, otherwise 0. Both SHALL be combinational from the registered indices.
REQ-026 Comparisons SHALL use the latched values truncated to LOOP_BIT; configuration values above 2^LOOP_BIT-1 are unsupported.
REQ-027 DRAIN SHALL last exactly DRAIN_CYC cycles with en=0, regardless of hold, and SHALL then go to DONE.
REQ-028 DONE SHALL last one cycle with done=1, then go to IDLE; done SHALL be 0 in all other states.
REQ-029 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE and DONE.
REQ-030 start SHALL be ignored outside IDLE, including a start that arrives in the same cycle as done.
REQ-031 err SHALL hold its value until the next accepted start.
REQ-032 en SHALL be 0 in every state except RUN.

Reset
REQ-033 While rst=1, the FSM SHALL be IDLE and en, busy, done, err, all indices and all latched configuration registers SHALL be 0, asynchronously.
REQ-034 A reset asserted mid-pass SHALL abandon the pass; after release the block SHALL accept a new start with no residual state.

Verification
REQ-035 M=1, ROUT=2, COUT=2, MP=2, nP=1, start at edge 0, hold=0 -> en=1 in cycles 1..16; index tuple (mm,niro,nico,ii,jj) in cycle 1 is (0,0,0,0,0), in cycle 2 is (0,0,0,0,1), in cycle 16 is (0,1,1,1,1); busy=1 in cycles 1..18; done=1 in cycle 19 only.
REQ-036 Same configuration with hold=1 in cycles 5..7 -> indices frozen during the stall, en=0 in cycles 5..7, 16 en cycles in total, done delayed to cycle 22.
REQ-037 nicc and nirr -> with COUT=3 and nP=2, nicc=2 only when nico=2; with ROUT=3 and nP=2, nirr=2 only when niro=2.
REQ-038 MP=0 at start -> no en cycles, done=1 on the next cycle, err=1 retained until the next accepted start.
REQ-039 rst pulsed in cycle 8 of a pass -> all outputs 0 immediately; a new start afterwards produces a complete 16-en pass.
REQ-040 start held high through a pass, and start coincident with done -> no restart until IDLE; exactly one pass counted per accepted start.
